// File: rtl/bus_traffic_gen.sv
// Scripted write/read-back traffic engine for one bus master port.
// Optional TRAFFIC_GEN_LFSR_EN selects an LFSR data pattern instead of SEED+idx.
module bus_traffic_gen #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    NUM_WORDS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 16'h1000,
    parameter int                    ADDR_STRIDE = 1,
    parameter logic [7:0]            SEED        = 8'h3C,
    parameter int                    TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic                  d_mode,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            err_count,
    output logic                  timeout
);
    // state   | meaning
    // IDLE    | waiting for start
    // WR_REQ  | write request presented, waiting for accept
    // WR_WAIT | write accepted, waiting for completion
    // RD_REQ  | read request presented, waiting for accept
    // RD_WAIT | read accepted, waiting for completion / data
    // FIN     | one-cycle done pulse, result published
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FIN} state_t;

    localparam logic [15:0]           TMR_LOAD = 16'(TIMEOUT - 1);
    localparam logic [7:0]            LAST_IDX = 8'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(ADDR_STRIDE);

    state_t                state, state_nxt;
    logic [7:0]            idx;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [15:0]           tmr;
    logic                  pass_r;
    logic                  wr_done, rd_done, tmo_hit, start_run;
    logic                  last, expired, mismatch;
    logic [DATA_WIDTH-1:0] pat;

    assign last      = (idx == LAST_IDX);
    assign expired   = (tmr == 16'd0);
    assign start_run = (state == IDLE) && start;
    assign mismatch  = rd_done && (d_rdata != pat);
    // pass is visible in the FIN cycle itself and then held by pass_r
    assign pass      = pass_r | ((state == FIN) && (err_count == 8'd0) && !timeout);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        d_valid   = 1'b0;
        d_mode    = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        wr_done   = 1'b0;
        rd_done   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = WR_REQ;
            end
            WR_REQ: begin
                busy    = 1'b1;
                d_valid = 1'b1;
                d_mode  = 1'b1;
                d_addr  = addr_r;
                d_wdata = pat;
                if (d_ready) state_nxt = WR_WAIT;
                else if (expired) begin
                    state_nxt = FIN;
                    tmo_hit   = 1'b1;
                end
            end
            WR_WAIT: begin
                busy = 1'b1;
                if (d_ready) begin
                    wr_done   = 1'b1;
                    state_nxt = last ? RD_REQ : WR_REQ;
                end else if (expired) begin
                    state_nxt = FIN;
                    tmo_hit   = 1'b1;
                end
            end
            RD_REQ: begin
                busy    = 1'b1;
                d_valid = 1'b1;
                d_addr  = addr_r;
                if (d_ready) state_nxt = RD_WAIT;
                else if (expired) begin
                    state_nxt = FIN;
                    tmo_hit   = 1'b1;
                end
            end
            RD_WAIT: begin
                busy = 1'b1;
                if (d_ready) begin
                    rd_done   = 1'b1;
                    state_nxt = last ? FIN : RD_REQ;
                end else if (expired) begin
                    state_nxt = FIN;
                    tmo_hit   = 1'b1;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state budget: reloaded on every state change, terminal count at zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                   tmr <= '0;
        else if (state_nxt != state) tmr <= TMR_LOAD;
        else if (busy)               tmr <= tmr - 16'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx       <= '0;
            addr_r    <= '0;
            err_count <= '0;
            pass_r    <= 1'b0;
            timeout   <= 1'b0;
        end else if (start_run) begin
            idx       <= '0;
            addr_r    <= BASE_ADDR;
            err_count <= '0;
            pass_r    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (wr_done || rd_done) begin
                if (last) begin
                    idx    <= '0;
                    addr_r <= BASE_ADDR;
                end else begin
                    idx    <= idx + 8'd1;
                    addr_r <= addr_r + STRIDE;
                end
            end
            if (mismatch && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            if (tmo_hit) timeout <= 1'b1;
            if (state == FIN) pass_r <= (err_count == 8'd0) && !timeout;
        end
    end

`ifdef TRAFFIC_GEN_LFSR_EN
    localparam logic [15:0] LFSR_SEED = (SEED == 8'h00) ? 16'h0001 : {8'h00, SEED};
    logic [15:0] lfsr;

    // Reloaded at the read phase so the read-back regenerates the write sequence
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                  lfsr <= LFSR_SEED;
        else if (start_run)         lfsr <= LFSR_SEED;
        else if (wr_done && last)   lfsr <= LFSR_SEED;
        else if (wr_done || rd_done)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign pat = DATA_WIDTH'(lfsr);
`else
    assign pat = DATA_WIDTH'(SEED) + DATA_WIDTH'(idx);
`endif

endmodule

// File: tb/tb_bus_traffic_gen.sv
// Bench for bus_traffic_gen: memory-backed slave with random stalls, corruption,
// hang and mid-run reset, checked against an index-based transaction model.
module tb_bus_traffic_gen;
    localparam int          NW   = 16;
    localparam int          TMO  = 20;
    localparam logic [15:0] BASE = 16'h1000;
`ifdef TRAFFIC_GEN_LFSR_EN
    localparam logic [7:0]  TB_SEED = 8'h00;
`else
    localparam logic [7:0]  TB_SEED = 8'h3C;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        d_ready = 1'b0;
    logic [7:0]  d_rdata = 8'h00;
    logic [7:0]  d_wdata;
    logic [15:0] d_addr;
    logic        d_valid, d_mode, busy, done, pass, timeout;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    bus_traffic_gen #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_WORDS(NW), .BASE_ADDR(BASE),
        .ADDR_STRIDE(1), .SEED(TB_SEED), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_addr(d_addr), .d_valid(d_valid), .d_ready(d_ready), .d_mode(d_mode),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .timeout(timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected data word for index k of a run
    function automatic logic [7:0] ref_pat(input int k);
`ifdef TRAFFIC_GEN_LFSR_EN
        logic [15:0] r;
        r = (TB_SEED == 8'h00) ? 16'h0001 : {8'h00, TB_SEED};
        for (int i = 0; i < k; i++) r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
        return r[7:0];
`else
        return 8'(int'(TB_SEED) + k);
`endif
    endfunction

    // scenario knobs, written only by the main sequence
    int stall_max    = 0;
    int hang_after   = -1;
    int corrupt_addr = -1;
    bit chk_stable   = 1'b0;

    // slave/monitor state, written only by the slave process
    logic [7:0]  mem [0:65535];
    int          phase = 0, stall = 0, txn = 0, wr_acc = 0, done_cnt = 0;
    int          cyc = 0, hang_cyc = 0, done_cyc = 0;
    logic        prev_busy = 1'b0, held = 1'b0, cur_mode = 1'b0;
    logic [15:0] cur_addr = '0, h_addr = '0;
    logic [7:0]  cur_wdata = '0, h_wdata = '0;
    logic        h_mode = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy && !prev_busy) done_cnt = 0;
        prev_busy = busy;
        if (held && chk_stable && rstn) begin
            chk("stall:valid_held", d_valid, 1);
            chk("stall:addr_held", d_addr, h_addr);
            chk("stall:wdata_held", d_wdata, h_wdata);
            chk("stall:mode_held", d_mode, h_mode);
        end
        if (!rstn || !busy) begin
            phase   = 0;
            d_ready = 1'b0;
            txn     = 0;
            wr_acc  = 0;
            stall   = $urandom_range(0, stall_max);
        end else if (phase == 0) begin
            if (d_valid && stall > 0) begin
                stall--;
                d_ready = 1'b0;
            end else if (d_valid) begin
                chk("txn:mode", d_mode, (txn < NW) ? 1 : 0);
                chk("txn:addr", d_addr, 32'(BASE) + 32'(txn % NW));
                chk("txn:wdata", d_wdata, (txn < NW) ? 32'(ref_pat(txn % NW)) : 0);
                cur_addr  = d_addr;
                cur_mode  = d_mode;
                cur_wdata = d_wdata;
                txn++;
                if (d_mode) begin
                    wr_acc++;
                    if (wr_acc == hang_after) hang_cyc = cyc;
                end
                d_ready = 1'b1;
                phase   = 1;
                stall   = $urandom_range(0, stall_max);
            end else d_ready = 1'b0;
        end else begin
            if (cur_mode && hang_after > 0 && wr_acc >= hang_after) d_ready = 1'b0;
            else if (stall > 0) begin
                stall--;
                d_ready = 1'b0;
            end else begin
                d_ready = 1'b1;
                phase   = 0;
                if (cur_mode) mem[cur_addr] = cur_wdata;
                else d_rdata = mem[cur_addr] ^ ((int'(cur_addr) == corrupt_addr) ? 8'h01 : 8'h00);
                stall = $urandom_range(0, stall_max);
            end
        end
        held    = d_valid && !d_ready;
        h_addr  = d_addr;
        h_wdata = d_wdata;
        h_mode  = d_mode;
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, ":ctl"}, {d_valid, d_mode, busy, done, pass, timeout}, 0);
        chk({tag, ":data"}, {err_count, d_addr, d_wdata}, 0);
    endtask

    // One complete run from a negedge; poke pulses start mid-run and in the FIN cycle
    task automatic run(input string name, input bit poke, input bit exp_pass,
                       input int exp_err, input bit exp_tmo, output int cycles);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, ":busy_after_start"}, busy, 1);
        cycles = 0;
        while (!done && cycles < 3000) begin
            start = poke && (cycles == 9);
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        chk({name, ":done_seen"}, done, 1);
        chk({name, ":pass"}, pass, exp_pass);
        chk({name, ":err_count"}, err_count, exp_err);
        chk({name, ":timeout"}, timeout, exp_tmo);
        chk({name, ":valid_low_at_done"}, d_valid, 0);
        chk({name, ":busy_low_at_done"}, busy, 0);
        start = poke;
        @(negedge clk);
        start = 1'b0;
        chk({name, ":fin_start_ignored"}, busy, 0);
        repeat (3) @(negedge clk);
        chk({name, ":one_done"}, done_cnt, 1);
        chk({name, ":pass_held"}, pass, exp_pass);
        chk({name, ":timeout_held"}, timeout, exp_tmo);
    endtask

    initial begin
        int cycles, n;
        #12;
        chk_reset_outs("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk_reset_outs("idle");

        run("ideal", 1'b0, 1'b1, 0, 1'b0, cycles);
        chk("ideal:cycles", cycles, 2 * 2 * NW);

        corrupt_addr = 32'h1005;
        run("corrupt", 1'b0, 1'b0, 1, 1'b0, cycles);
        for (int r = 0; r < 2; r++) begin
            corrupt_addr = int'(BASE) + int'($urandom_range(0, NW - 1));
            run("corrupt_rnd", 1'b1, 1'b0, 1, 1'b0, cycles);
        end
        corrupt_addr = -1;

        hang_after = 3;
        run("hang", 1'b0, 1'b0, 0, 1'b1, cycles);
        chk("hang:latency", done_cyc - hang_cyc, TMO + 1);
        hang_after = -1;

        stall_max  = 7;
        chk_stable = 1'b1;
        for (int r = 0; r < 3; r++) run("stall", r == 1, 1'b1, 0, 1'b0, cycles);
        chk_stable = 1'b0;
        stall_max  = 0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (txn < NW + 8 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort:reached_8th_read", (txn >= NW + 8) ? 1 : 0, 1);
        #2 rstn = 1'b0;
        #1 chk_reset_outs("abort");
        repeat (3) @(negedge clk);
        chk("abort:no_done", done_cnt, 0);
        rstn = 1'b1;
        @(negedge clk);
        run("after_abort", 1'b0, 1'b1, 0, 1'b0, cycles);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
